reg_file_sb: RTL and testbench

Parametrised multi-read, dual-write register file with per-register pending scoreboard, the successor to the CPU's single-write 32x32 register file. Sits in the decode stage: read ports feed operand fetch, write port 0 takes pipeline writeback, write port 1 takes a long-latency unit (load/multiply). The scoreboard tracks destinations in flight and raises a stall when a source is pending and not bypassable.

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_scoreboard.sv | 83 ++++++++
 rtl/reg_file_sb.sv | 110 +++++++++++
 tb/tb_reg_file_sb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and helpers for the scoreboarded register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default parameter values
//   reg_addr_t                           : register address at the default width
//   port_lsb()                           : bit offset of port k inside a packed
//                                          multi-port bus
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    // Read ports are packed side by side, port k at [k*width +: width].
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits for destinations in flight.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr0_*/wr1_*           : write-port enables, clear-on-write flags, addresses
//   iss_en, iss_addr      : mark a destination register pending
//   flush                 : drop every pending bit
//   rd_addr / rd_busy     : per read port, source pending and not retired now
//   pend_cnt              : registered population count of the pending vector
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr0_en,
    input  logic                     wr0_clr,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic                     wr1_en,
    input  logic                     wr1_clr,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic [DEPTH-1:0] clr_hit;
    logic [DEPTH-1:0] iss_hit;
    logic [ADDR_W:0]  cnt_reg;
    logic [ADDR_W:0]  cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            localparam bit HARD_ZERO = (ZERO_R0 != 0) && (gi == 0);

            assign clr_hit[gi] = (wr0_en & wr0_clr & (wr0_addr == IDX))
                               | (wr1_en & wr1_clr & (wr1_addr == IDX));
            assign iss_hit[gi] = iss_en & (iss_addr == IDX) & ~HARD_ZERO;
            // Issue is applied last so a new producer survives the retirement
            // of the previous one and a flush in the same cycle.
            assign pending_next[gi] = iss_hit[gi]
                                    | (pending_reg[gi] & ~flush & ~clr_hit[gi]);
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_busy
            logic [ADDR_W-1:0] src;
            assign src = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
            // A clearing write this cycle retires the source, so no stall.
            assign rd_busy[gi] = pending_reg[src] & ~clr_hit[src];
        end
    endgenerate

    // Count is taken from the next-state vector so it lands with it.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign pend_cnt = cnt_reg;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read, dual-write register file with pending scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_addr / rd_data   : NUM_RD combinational read ports with write bypass
//   rd_busy, stall      : per-port source pending, and their OR
//   wr0_*               : pipeline writeback port
//   wr1_*               : long-latency unit port (wins on address collision)
//   iss_en, iss_addr    : mark destination pending at issue
//   flush               : clear all pending bits
//   pend_cnt            : number of pending registers (registered)
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wr0_en,
    input  logic                     wr0_clr,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic                     wr1_clr,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_R0 != 0);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              we0;
    logic              we1;

    assign we0 = wr0_en & ~(HAS_ZERO && (wr0_addr == '0));
    assign we1 = wr1_en & ~(HAS_ZERO && (wr1_addr == '0));

    // Port 1 is written after port 0 so it takes a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (we0) begin
                mem_reg[wr0_addr] <= wr0_data;
            end
            if (we1) begin
                mem_reg[wr1_addr] <= wr1_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] src;
            logic [DATA_W-1:0] port_data;

            assign src = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];

            always_comb begin
                port_data = mem_reg[src];
                if (HAS_ZERO && (src == '0)) begin
                    port_data = '0;
                end else if (wr1_en && (wr1_addr == src)) begin
                    port_data = wr1_data;
                end else if (wr0_en && (wr0_addr == src)) begin
                    port_data = wr0_data;
                end
            end

            assign rd_data[port_lsb(gi, DATA_W) +: DATA_W] = port_data;
        end
    endgenerate

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en),
        .wr0_clr  (wr0_clr),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_clr  (wr1_clr),
        .wr1_addr (wr1_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

    assign stall = |rd_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     stall;
    logic                     wr0_en, wr0_clr, wr1_en, wr1_clr, iss_en, flush;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr, iss_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data;
    logic [ADDR_W:0]          pend_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: register contents and pending flags.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_pend [DEPTH];

    reg_file_sb #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .ZERO_R0 (1)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy), .stall (stall),
        .wr0_en (wr0_en), .wr0_clr (wr0_clr), .wr0_addr (wr0_addr), .wr0_data (wr0_data),
        .wr1_en (wr1_en), .wr1_clr (wr1_clr), .wr1_addr (wr1_addr), .wr1_data (wr1_data),
        .iss_en (iss_en), .iss_addr (iss_addr), .flush (flush), .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_read(input int a);
        if (a == 0) return '0;
        if (wr1_en && int'(wr1_addr) == a) return wr1_data;
        if (wr0_en && int'(wr0_addr) == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input int a);
        bit retiring;
        retiring = (wr0_en && wr0_clr && int'(wr0_addr) == a) ||
                   (wr1_en && wr1_clr && int'(wr1_addr) == a);
        return m_pend[a] && !retiring;
    endfunction

    function automatic int exp_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 0;
        end
    endtask

    // Applies the current inputs to the model exactly as a clock edge would.
    task automatic model_commit();
        bit set_now = iss_en && iss_addr != 0;
        if (flush) for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
        if (wr0_en && wr0_clr) m_pend[wr0_addr] = 0;
        if (wr1_en && wr1_clr) m_pend[wr1_addr] = 0;
        if (set_now) m_pend[iss_addr] = 1;
        if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
    endtask

    task automatic idle();
        wr0_en = 0; wr0_clr = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_clr = 0; wr1_addr = '0; wr1_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic test_reset();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, a); set_rd(1, (a + 1) % DEPTH);
            #1;
            checks++;
            if (rd_data !== '0 || rd_busy !== '0) begin
                failures++;
                $display("FAIL reset_read a=%0d got data=%h busy=%b need 0/0", a, rd_data, rd_busy);
            end
        end
        checks++;
        if (pend_cnt !== '0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got pend_cnt=%0d stall=%b need 0/0", pend_cnt, stall);
        end
        $display("test_reset: %0d addresses read", DEPTH);
    endtask

    task automatic test_dual_write();
        idle(); set_rd(0, 5);
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11;
        wr1_en = 1; wr1_addr = 5; wr1_data = 32'h22;
        #1;
        checks++;
        if (rd_data[0 +: DATA_W] !== 32'h22) begin
            failures++;
            $display("FAIL dual_bypass got %h need 00000022", rd_data[0 +: DATA_W]);
        end
        cycle(); idle(); #1;
        checks++;
        if (rd_data[0 +: DATA_W] !== 32'h22) begin
            failures++;
            $display("FAIL dual_array got %h need 00000022", rd_data[0 +: DATA_W]);
        end
        $display("test_dual_write: r5 <- 0x11 | 0x22");
    endtask

    task automatic test_issue_clear();
        idle(); iss_en = 1; iss_addr = 7;
        cycle(); idle(); set_rd(1, 7); #1;
        checks++;
        if (rd_busy[1] !== 1'b1 || stall !== 1'b1 || pend_cnt !== 6'd1) begin
            failures++;
            $display("FAIL issue_busy got busy=%b stall=%b cnt=%0d need 1/1/1", rd_busy[1], stall, pend_cnt);
        end
        wr1_en = 1; wr1_clr = 1; wr1_addr = 7; wr1_data = 32'hABCD; #1;
        checks++;
        if (rd_data[DATA_W +: DATA_W] !== 32'hABCD || rd_busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL clear_bypass got data=%h busy=%b need 0000abcd/0", rd_data[DATA_W +: DATA_W], rd_busy[1]);
        end
        cycle(); idle(); #1;
        checks++;
        if (pend_cnt !== 6'd0 || rd_data[DATA_W +: DATA_W] !== 32'hABCD) begin
            failures++;
            $display("FAIL clear_after got cnt=%0d data=%h need 0/0000abcd", pend_cnt, rd_data[DATA_W +: DATA_W]);
        end
        $display("test_issue_clear: r7 issued then retired by wr1");
    endtask

    task automatic test_issue_over_clear();
        idle(); iss_en = 1; iss_addr = 3;
        cycle();
        idle(); set_rd(0, 3);
        wr0_en = 1; wr0_clr = 1; wr0_addr = 3; wr0_data = 32'h33;
        iss_en = 1; iss_addr = 3;
        cycle(); idle(); #1;
        checks++;
        if (pend_cnt !== 6'd1 || rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL issue_over_clear got cnt=%0d busy=%b need 1/1", pend_cnt, rd_busy[0]);
        end
        // Without clr the data bypasses but the source stays busy.
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h44; #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[0 +: DATA_W] !== 32'h44) begin
            failures++;
            $display("FAIL noclr_busy got busy=%b data=%h need 1/00000044", rd_busy[0], rd_data[0 +: DATA_W]);
        end
        wr0_clr = 1;
        cycle(); idle(); #1;
        checks++;
        if (pend_cnt !== 6'd0) begin
            failures++;
            $display("FAIL r3_retire got cnt=%0d need 0", pend_cnt);
        end
        $display("test_issue_over_clear: r3 reissued while retiring");
    endtask

    task automatic test_zero_r0();
        idle(); set_rd(0, 0);
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF;
        iss_en = 1; iss_addr = 0; #1;
        checks++;
        if (rd_data[0 +: DATA_W] !== '0 || rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_bypass got data=%h busy=%b need 0/0", rd_data[0 +: DATA_W], rd_busy[0]);
        end
        cycle(); idle(); #1;
        checks++;
        if (rd_data[0 +: DATA_W] !== '0 || rd_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
            failures++;
            $display("FAIL zero_after got data=%h busy=%b cnt=%0d need 0/0/0", rd_data[0 +: DATA_W], rd_busy[0], pend_cnt);
        end
        $display("test_zero_r0: r0 write and issue ignored");
    endtask

    task automatic test_flush();
        int regs[3] = '{1, 2, 4};
        for (int i = 0; i < 3; i++) begin
            idle(); iss_en = 1; iss_addr = ADDR_W'(regs[i]);
            cycle();
        end
        idle(); #1;
        checks++;
        if (pend_cnt !== 6'd3) begin
            failures++;
            $display("FAIL three_pending got cnt=%0d need 3", pend_cnt);
        end
        flush = 1; iss_en = 1; iss_addr = 9;
        cycle(); idle(); set_rd(0, 9); set_rd(1, 1); #1;
        checks++;
        if (pend_cnt !== 6'd1 || rd_busy !== 2'b01) begin
            failures++;
            $display("FAIL flush_issue got cnt=%0d busy=%b need 1/01", pend_cnt, rd_busy);
        end
        $display("test_flush: flush with same-cycle issue of r9");
    endtask

    task automatic test_random();
        int pa;
        for (int n = 0; n < 400; n++) begin
            idle();
            wr0_en = 1'($urandom_range(0, 1)); wr0_clr = 1'($urandom_range(0, 1));
            wr1_en = 1'($urandom_range(0, 2) == 0); wr1_clr = 1'($urandom_range(0, 1));
            wr0_addr = ADDR_W'($urandom_range(0, 7)); wr1_addr = ADDR_W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wr1_addr = ADDR_W'($urandom);
            wr0_data = $urandom; wr1_data = $urandom;
            iss_en = 1'($urandom_range(0, 1)); iss_addr = ADDR_W'($urandom_range(0, 9));
            flush = 1'($urandom_range(0, 24) == 0);
            for (int k = 0; k < NUM_RD; k++) set_rd(k, $urandom_range(0, 9));
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                pa = int'(rd_addr[k*ADDR_W +: ADDR_W]);
                checks++;
                if (rd_data[k*DATA_W +: DATA_W] !== exp_read(pa) || rd_busy[k] !== exp_busy(pa)) begin
                    failures++;
                    $display("FAIL rand_read n=%0d port=%0d a=%0d got %h/%b need %h/%b", n, k, pa,
                             rd_data[k*DATA_W +: DATA_W], rd_busy[k], exp_read(pa), exp_busy(pa));
                end
            end
            checks++;
            if (stall !== (|rd_busy)) begin
                failures++;
                $display("FAIL rand_stall n=%0d got %b need %b", n, stall, |rd_busy);
            end
            cycle();
            checks++;
            if (int'(pend_cnt) != exp_count()) begin
                failures++;
                $display("FAIL rand_count n=%0d got %0d need %0d", n, pend_cnt, exp_count());
            end
        end
        $display("test_random: 400 cycles against model");
    endtask

    task automatic test_async_reset();
        idle();
        wr0_en = 1; wr0_addr = 12; wr0_data = 32'hCAFE; iss_en = 1; iss_addr = 12;
        cycle(); idle(); set_rd(0, 12); set_rd(1, 12); #1;
        checks++;
        if (pend_cnt == 6'd0 || rd_data[0 +: DATA_W] !== 32'hCAFE) begin
            failures++;
            $display("FAIL pre_reset got cnt=%0d data=%h need >0/0000cafe", pend_cnt, rd_data[0 +: DATA_W]);
        end
        #1 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (pend_cnt !== '0 || rd_busy !== '0 || stall !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d busy=%b stall=%b data=%h need all 0",
                     pend_cnt, rd_busy, stall, rd_data);
        end
        @(negedge clk); rst_n = 1; #1;
        $display("test_async_reset: reset asserted between edges");
    endtask

    initial begin
        rst_n = 0; rd_addr = '0; idle(); model_reset();
        #12 rst_n = 1;
        test_reset();
        test_dual_write();
        test_issue_clear();
        test_issue_over_clear();
        test_zero_r0();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
